// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames each accepted word as start, LSB-first data,
// optional parity and 1-2 stop bits, with zero-gap back-to-back frames.
module uart_tx_serializer #(
    parameter int BITWIDTH   = 8,
    parameter int BAUD_DIV   = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                tClk,
    input  logic                tRst,
    input  logic [BITWIDTH-1:0] tdataIn,
    input  logic                tLoad,
    output logic                tReady,
    output logic                tBusy,
    output logic                tDone,
    output logic                tTxd,
    output logic [2:0]          dbg_state
);

    localparam int BCW = $clog2(BAUD_DIV);
    localparam int CW  = $clog2(BITWIDTH + 1);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]  LAST_DATA = CW'(BITWIDTH - 1);
    localparam logic [CW-1:0]  LAST_STOP = CW'(STOP_BITS - 1);
    localparam logic           ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [BCW-1:0]        baud_q, baud_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [BITWIDTH-1:0]   shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  baud_end;
    logic                  done_c;
    logic                  ready_c;

    always_ff @(posedge tClk or negedge tRst) begin
        if (!tRst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        txd_d    = 1'b1;
        busy_d   = 1'b0;

        baud_end = (baud_q == BAUD_LAST);
        done_c   = (state_q == S_STOP) && baud_end && (bit_q == LAST_STOP);
        ready_c  = (state_q == S_IDLE) || done_c;

        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                // shift_q[0] always holds the bit currently on the line
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Accept overrides the stop->idle step so the next start bit has no gap
        if (tLoad && ready_c) begin
            state_d  = S_START;
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = tdataIn;
            parity_d = (^tdataIn) ^ ODD_BIT;
        end

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign tReady    = ready_c;
    assign tDone     = done_c;
    assign tBusy     = busy_q;
    assign tTxd      = txd_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: 8N1, even and odd parity instances
// at BAUD_DIV=4, with hand-written expected line sequences.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tdata;
  logic [2:0] load;
  logic [2:0] ready;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] txd;
  logic [2:0] st0, st1, st2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.BITWIDTH(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .tClk(clk), .tRst(rst_n), .tdataIn(tdata), .tLoad(load[0]),
    .tReady(ready[0]), .tBusy(busy[0]), .tDone(done[0]), .tTxd(txd[0]), .dbg_state(st0)
  );

  uart_tx_serializer #(.BITWIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .tClk(clk), .tRst(rst_n), .tdataIn(tdata), .tLoad(load[1]),
    .tReady(ready[1]), .tBusy(busy[1]), .tDone(done[1]), .tTxd(txd[1]), .dbg_state(st1)
  );

  uart_tx_serializer #(.BITWIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .tClk(clk), .tRst(rst_n), .tdataIn(tdata), .tLoad(load[2]),
    .tReady(ready[2]), .tBusy(busy[2]), .tDone(done[2]), .tTxd(txd[2]), .dbg_state(st2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge: word is accepted at the following posedge.
  task automatic begin_frame(input int id, input logic [7:0] word);
    tdata    = word;
    load[id] = 1'b1;
  endtask

  // exp_bits lists line levels with the first transmitted bit leftmost.
  task automatic check_frame(input int id, input logic [15:0] exp_bits, input int nbits,
                             input string tag, input logic nxt_load, input logic [7:0] nxt_word,
                             input int drop_k);
    int last;
    last = nbits * 4 - 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      chk($sformatf("%s k%0d txd", tag, k), {31'd0, txd[id]}, {31'd0, exp_bits[nbits - 1 - k / 4]});
      chk($sformatf("%s k%0d done", tag, k), {31'd0, done[id]}, (k == last) ? 32'd1 : 32'd0);
      chk($sformatf("%s k%0d busy", tag, k), {31'd0, busy[id]}, 32'd1);
      chk($sformatf("%s k%0d ready", tag, k), {31'd0, ready[id]}, (k == last) ? 32'd1 : 32'd0);
      if (k == 0) begin
        load[id] = nxt_load;
        tdata    = nxt_word;
      end
      if (k == drop_k) load[id] = 1'b0;
    end
  endtask

  task automatic check_idle(input int id, input string tag);
    @(negedge clk);
    chk({tag, " idle txd"}, {31'd0, txd[id]}, 32'd1);
    chk({tag, " idle busy"}, {31'd0, busy[id]}, 32'd0);
    chk({tag, " idle ready"}, {31'd0, ready[id]}, 32'd1);
    chk({tag, " idle done"}, {31'd0, done[id]}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 3'b000;
    tdata = 8'h00;

    repeat (2) @(negedge clk);
    load  = 3'b111;
    tdata = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int id = 0; id < 3; id++) begin
        chk($sformatf("rst%0d c%0d txd", id, c), {31'd0, txd[id]}, 32'd1);
        chk($sformatf("rst%0d c%0d busy", id, c), {31'd0, busy[id]}, 32'd0);
        chk($sformatf("rst%0d c%0d done", id, c), {31'd0, done[id]}, 32'd0);
      end
    end
    load  = 3'b000;
    rst_n = 1'b1;
    @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("post_rst%0d ready", id), {31'd0, ready[id]}, 32'd1);
      chk($sformatf("post_rst%0d txd", id), {31'd0, txd[id]}, 32'd1);
    end
    chk("post_rst state0", {29'd0, st0}, 32'd0);

    // 8N1 0xA5: 0 1010 0101 1
    begin_frame(0, 8'hA5);
    check_frame(0, 16'b0101001011, 10, "8n1_a5", 1'b0, 8'h5A, -1);
    check_idle(0, "8n1_a5");

    // 0xA5 has four ones: even parity 0, odd parity 1
    begin_frame(1, 8'hA5);
    check_frame(1, 16'b01010010101, 11, "par_even_a5", 1'b0, 8'h00, -1);
    check_idle(1, "par_even_a5");

    begin_frame(2, 8'hA5);
    check_frame(2, 16'b01010010111, 11, "par_odd_a5", 1'b0, 8'h00, -1);
    check_idle(2, "par_odd_a5");

    // Back-to-back 0x55 then 0x0F with load held until accepted
    begin_frame(0, 8'h55);
    check_frame(0, 16'b0101010101, 10, "b2b_55", 1'b1, 8'h0F, -1);
    check_frame(0, 16'b0111100001, 10, "b2b_0f", 1'b0, 8'hAA, -1);
    check_idle(0, "b2b");

    // 0xFF offered mid-frame of 0x00 and withdrawn before the final stop clock
    begin_frame(0, 8'h00);
    check_frame(0, 16'b0000000001, 10, "busy_00", 1'b1, 8'hFF, 35);
    check_idle(0, "busy_00");

    // Reset during data bit 3 of 0x00 (clocks 16..19 after accept)
    begin_frame(0, 8'h00);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0) load[0] = 1'b0;
    end
    chk("midrst before txd", {31'd0, txd[0]}, 32'd0);
    chk("midrst before busy", {31'd0, busy[0]}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst txd", {31'd0, txd[0]}, 32'd1);
    chk("midrst busy", {31'd0, busy[0]}, 32'd0);
    chk("midrst done", {31'd0, done[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst release ready", {31'd0, ready[0]}, 32'd1);
    chk("midrst release txd", {31'd0, txd[0]}, 32'd1);

    // 0x3C: 0 0011 1100 1
    begin_frame(0, 8'h3C);
    check_frame(0, 16'b0001111001, 10, "post_rst_3c", 1'b0, 8'hC3, -1);
    check_idle(0, "post_rst_3c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
